// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-arbiter state encoding.
package uart_pkg;

  localparam int unsigned DefaultClksPerBit = 87;  // 10 MHz clock, 115200 baud
  localparam int unsigned TimeoutMult       = 12;  // bit times allowed per byte before giving up

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle around the shared UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_dv;
  logic [7:0]           tx_byte;
  logic                 tx_done;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    input  req, req_data, req_last, tx_done,
    output req_ack, grant, tx_dv, tx_byte, busy, timeout_err
  );

  modport slave (
    output req, req_data, req_last, tx_done,
    input  req_ack, grant, tx_dv, tx_byte, busy, timeout_err
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit above ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner = '0;
    index  = '0;
    cand   = '0;
    found  = 1'b0;
    // Offset NUM_REQ lands back on ptr itself, so the last owner is considered last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters; a grant is held for a whole message.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IdxW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TimeoutLimit = TimeoutMult * CLKS_PER_BIT;
  localparam int unsigned CntW         = $clog2(TimeoutLimit + 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] req_ack_q;
  logic [IdxW-1:0]    gidx_q;
  logic [IdxW-1:0]    ptr_q;
  logic               tx_dv_q;
  logic [7:0]         tx_byte_q;
  logic               last_q;
  logic               timeout_q;
  logic [CntW-1:0]    cnt_q;

  logic [NUM_REQ-1:0] pick_winner;
  logic [IdxW-1:0]    pick_index;
  logic [7:0]         sel_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .index  (pick_index)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IdxW'(i)) sel_data = bus.req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      req_ack_q <= '0;
      gidx_q    <= '0;
      ptr_q     <= IdxW'(NUM_REQ - 1);
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      req_ack_q <= '0;
      tx_dv_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|bus.req) begin
            grant_q <= pick_winner;
            gidx_q  <= pick_index;
            state_q <= StSend;
          end
        end
        StSend: begin
          tx_dv_q   <= 1'b1;
          req_ack_q <= grant_q;
          tx_byte_q <= sel_data;
          last_q    <= bus.req_last[gidx_q];
          cnt_q     <= '0;
          state_q   <= StWait;
        end
        StWait: begin
          // tx_done takes priority over a timeout landing on the same edge.
          if (bus.tx_done) begin
            cnt_q <= '0;
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= gidx_q;
              state_q <= StIdle;
            end else if (bus.req[gidx_q]) begin
              state_q <= StSend;
            end else begin
              state_q <= StHold;
            end
          end else if (cnt_q == CntW'(TimeoutLimit - 1)) begin
            timeout_q <= 1'b1;
            grant_q   <= '0;
            ptr_q     <= gidx_q;
            cnt_q     <= '0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (bus.req[gidx_q]) state_q <= StSend;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.req_ack     = req_ack_q;
  assign bus.tx_dv       = tx_dv_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requesters sharing one UART transmitter.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 87: clocks per UART bit at 10 MHz and 115200 baud; sets the timeout limit.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester byte-valid, held until acked.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NUM_REQ  marks the current byte as last of message.
REQ-008 SHALL have port req_ack  output  NUM_REQ  one-cycle pulse, byte accepted.
REQ-009 SHALL have port grant  output  NUM_REQ  one-hot owner of transmitter, held for the whole message.
REQ-010 SHALL have port tx_dv  output  1  one-cycle start strobe to UART transmitter.
REQ-011 SHALL have port tx_byte  output  8  byte to transmit.
REQ-012 SHALL have port tx_done  input  1  one-cycle pulse from transmitter, byte finished.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on transmitter timeout.

Function
REQ-015 SHALL implement the states IDLE, SEND, WAIT and HOLD.
REQ-016 In IDLE with any req bit high, the rising edge SHALL set grant to the round-robin winner and move to SEND.
REQ-017 Round-robin SHALL search from index ptr+1 upward, wrapping modulo NUM_REQ; ptr is the last granted index.
REQ-018 ptr SHALL update only when a message ends or times out.
REQ-019 In SEND, for exactly one cycle: tx_dv=1, req_ack[g]=1, and tx_byte SHALL register req_data of grant g.
REQ-020 SEND SHALL latch req_last[g] and then move to WAIT.
REQ-021 tx_byte SHALL hold stable from SEND until the next SEND.
REQ-022 In WAIT, on tx_done with the latched last bit set: grant SHALL clear, ptr SHALL become g, and the state SHALL move to IDLE.
REQ-023 In WAIT, on tx_done with the latched last bit clear: move to SEND if req[g]=1, else move to HOLD.
REQ-024 HOLD SHALL keep grant and move to SEND on the first cycle req[g]=1; other requesters SHALL be ignored while in HOLD.
REQ-025 WAIT SHALL count clocks from entry; at count = 12*CLKS_PER_BIT without tx_done it SHALL pulse timeout_err, clear grant, set ptr=g and go to IDLE.
REQ-026 Timeout counter width SHALL be $clog2(12*CLKS_PER_BIT+1); the counter SHALL clear on every WAIT entry.
REQ-027 tx_done outside WAIT SHALL be ignored.
REQ-028 tx_done and the timeout limit in the same cycle SHALL resolve as tx_done, with no timeout_err.
REQ-029 Back-to-back messages: minimum gap SHALL be one IDLE cycle between the last tx_done and the next grant.
REQ-030 Requests from a non-granted requester SHALL never be acked and SHALL remain pending without loss.

Reset
REQ-031 While rst=0, outputs SHALL immediately be: grant=0, req_ack=0, tx_dv=0, tx_byte=8'h00, busy=0, timeout_err=0.
REQ-032 While rst=0, internal values SHALL be: state=IDLE, ptr=NUM_REQ-1 (requester 0 wins first), counter=0, latched last=0.
REQ-033 Reset asserted mid-message SHALL abandon that message; no ack or strobe SHALL follow the release.
REQ-034 Reset release SHALL be synchronous to clk; the first arbitration occurs on the first edge after release.

Structure
REQ-035 State encodings and the timeout multiplier (12) SHALL reside in the shared package uart_pkg, alongside the existing CLKS_PER_BIT default.
REQ-036 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: req, ptr; outputs: one-hot winner, index).
REQ-037 The FSM, counter and datapath registers SHALL remain in uart_tx_arbiter.

Verification
REQ-038 Single byte: req[0]=1, data 8'h31, last=1 -> grant=001 next edge; tx_dv and req_ack[0] one cycle later; tx_byte=8'h31; grant clears after tx_done.
REQ-039 Contention: req=111 simultaneously, each with one last-byte -> tx order 0,1,2.
REQ-040 Fairness after contention: a second round with req=101 -> order 2?no: ptr=2, so order 0 then 2.
REQ-041 Message lock: req[1] sends 8'h4C,8'h32 (last on second) while req[0] is pending -> both req[1] bytes are transmitted before any grant to 0.
REQ-042 HOLD: req[1] drops after the first, non-last byte for 500 cycles -> grant stays 010, req[0] is not acked, and the second byte is sent on reassertion.
REQ-043 Timeout: tx_done suppressed -> timeout_err pulses exactly 1044 cycles after WAIT entry and the arbiter returns to IDLE.
REQ-044 Reset mid-WAIT: rst low for 2 cycles -> all outputs are 0 immediately, and the next request is served starting from requester 0.
